// File: rtl/alu_bist.sv
// alu_bist: self-test initiator for the combinational ALU; drives LFSR-random and corner
// vectors for every op, checks ALUResult/zero against a golden model, records failures.
module alu_bist #(
   parameter int               WIDTH      = 32,
   parameter int               NUM_RANDOM = 10,
   parameter logic [WIDTH-1:0] SEED       = 'hACE1_2468,
   parameter logic [WIDTH-1:0] LFSR_TAPS  = 'h8020_0003
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   output logic [WIDTH-1:0] srcA,
   output logic [WIDTH-1:0] srcB,
   output logic [2:0]       ALUControl,
   input  logic [WIDTH-1:0] ALUResult,
   input  logic             zero,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [7:0]       err_count,
   output logic             fail_valid,
   output logic [2:0]       fail_op,
   output logic [7:0]       fail_idx
);
   typedef enum logic [1:0] {S_IDLE, S_APPLY, S_DONE} state_t;

   localparam logic [7:0]       LAST  = 8'(NUM_RANDOM + 24);
   localparam logic [7:0]       NRAND = 8'(NUM_RANDOM);
   localparam logic [WIDTH-1:0] C_MAX = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [WIDTH-1:0] C_MIN = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [WIDTH-1:0] C_ONE = WIDTH'(1);

   function automatic logic [WIDTH-1:0] f_step(input logic [WIDTH-1:0] s);
      return (s >> 1) ^ (s[0] ? LFSR_TAPS : '0);
   endfunction

   function automatic logic [WIDTH-1:0] f_corner(input logic [2:0] k);
      return k == 3'd0 ? '0 : k == 3'd1 ? '1 : k == 3'd2 ? C_MAX : k == 3'd3 ? C_MIN : C_ONE;
   endfunction

   state_t           r_state, w_next;
   logic [WIDTH-1:0] r_lfsr;
   logic [2:0]       r_op, r_ci, r_cj;
   logic [7:0]       r_idx, r_err, r_fail_idx;
   logic             r_fail_valid;
   logic [2:0]       r_fail_op;

   logic [WIDTH-1:0] w_a1, w_a2, w_va, w_vb, w_exp;
   logic             w_rand, w_last, w_mis, w_apply;

   // Random vectors come straight off two LFSR steps so vector 0 is visible the cycle after start.
   assign w_a1    = f_step(r_lfsr);
   assign w_a2    = f_step(w_a1);
   assign w_rand  = r_idx < NRAND;
   assign w_last  = r_idx == LAST;
   assign w_apply = r_state == S_APPLY;
   assign w_va    = w_rand ? w_a1 : f_corner(r_ci);
   assign w_vb    = w_rand ? w_a2 : f_corner(r_cj);
   assign w_exp   = r_op == 3'd0 ? w_va + w_vb :
                    r_op == 3'd1 ? w_va - w_vb :
                    r_op == 3'd2 ? w_va & w_vb :
                    r_op == 3'd3 ? w_va | w_vb :
                    {{(WIDTH-1){1'b0}}, $signed(w_va) < $signed(w_vb)};
   assign w_mis   = (ALUResult != w_exp) || (zero != (w_exp == '0));

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next;

   always_comb begin
      w_next = r_state;
      if (w_apply) w_next = (r_op == 3'd4 && w_last) ? S_DONE : S_APPLY;
      else if (start) w_next = S_APPLY;
   end

   always_comb begin
      busy       = w_apply;
      done       = r_state == S_DONE;
      pass       = r_state == S_DONE && r_err == 8'd0;
      srcA       = w_apply ? w_va : '0;
      srcB       = w_apply ? w_vb : '0;
      ALUControl = w_apply ? r_op : 3'd0;
      err_count  = r_err;
      fail_valid = r_fail_valid;
      fail_op    = r_fail_op;
      fail_idx   = r_fail_idx;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_lfsr       <= SEED;
         r_op         <= 3'd0;
         r_idx        <= 8'd0;
         r_ci         <= 3'd0;
         r_cj         <= 3'd0;
         r_err        <= 8'd0;
         r_fail_valid <= 1'b0;
         r_fail_op    <= 3'd0;
         r_fail_idx   <= 8'd0;
      end else if (!w_apply && start) begin
         r_lfsr       <= SEED;
         r_op         <= 3'd0;
         r_idx        <= 8'd0;
         r_ci         <= 3'd0;
         r_cj         <= 3'd0;
         r_err        <= 8'd0;
         r_fail_valid <= 1'b0;
         r_fail_op    <= 3'd0;
         r_fail_idx   <= 8'd0;
      end else if (w_apply) begin
         if (w_rand) r_lfsr <= w_a2;
         else begin
            r_cj <= r_cj == 3'd4 ? 3'd0 : r_cj + 3'd1;
            if (r_cj == 3'd4) r_ci <= r_ci == 3'd4 ? 3'd0 : r_ci + 3'd1;
         end
         r_idx <= w_last ? 8'd0 : r_idx + 8'd1;
         if (w_last) r_op <= r_op + 3'd1;
         if (w_mis) begin
            if (r_err != 8'hFF) r_err <= r_err + 8'd1;
            if (!r_fail_valid) begin
               r_fail_valid <= 1'b1;
               r_fail_op    <= r_op;
               r_fail_idx   <= r_idx;
            end
         end
      end
   end
endmodule

// File: tb/tb_alu_bist.sv
// tb_alu_bist: drives two BIST instances (NUM_RANDOM 10 and 0) against a behavioural ALU
// with selectable faults and checks vector stream and results against a reference model.
module tb_alu_bist;
   localparam int          W    = 32;
   localparam int          NR   = 10;
   localparam int          TOT  = 5 * (NR + 25);
   localparam logic [31:0] SEED = 32'hACE1_2468;
   localparam logic [31:0] TAPS = 32'h8020_0003;

   typedef struct {logic [31:0] a; logic [31:0] b; logic [2:0] op; int idx;} vec_t;

   logic clk = 1'b0, rst_n = 1'b1, start = 1'b0;
   logic [W-1:0] a1, b1, r1, a0, b0, r0;
   logic [2:0]   c1, c0, fop1, fop0;
   logic         z1, z0, busy1, busy0, done1, done0, pass1, pass0, fv1, fv0;
   logic [7:0]   err1, err0, fidx1, fidx0;

   int         mode = 0;
   logic [2:0] fault_op = 3'd0;
   logic [1:0] fault_key = 2'd0;
   int         n_cmp = 0, n_bad = 0;
   vec_t       vq[$];
   logic [31:0] cor[5] = '{32'h0, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000, 32'h1};

   always #5 clk = ~clk;

   function automatic logic [31:0] golden(input logic [31:0] a, b, input logic [2:0] op);
      case (op)
         3'd0:    return a + b;
         3'd1:    return a - b;
         3'd2:    return a & b;
         3'd3:    return a | b;
         default: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      endcase
   endfunction

   // ALU under test: mode 1 unsigned SLT, mode 2 zero stuck low, mode 3 data-dependent bit flip
   function automatic logic [32:0] alu(input logic [31:0] a, b, input logic [2:0] op,
                                       input int m, input logic [2:0] fo, input logic [1:0] fk);
      logic [31:0] r;
      r = golden(a, b, op);
      if (m == 1 && op == 3'd4) r = {31'b0, a < b};
      if (m == 3 && op == fo && a[1:0] == fk) r[0] = ~r[0];
      return {(m == 2) ? 1'b0 : (r == 32'd0), r};
   endfunction

   assign {z1, r1} = alu(a1, b1, c1, mode, fault_op, fault_key);
   assign {z0, r0} = alu(a0, b0, c0, mode, fault_op, fault_key);

   alu_bist #(.NUM_RANDOM(NR)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .srcA(a1), .srcB(b1), .ALUControl(c1),
      .ALUResult(r1), .zero(z1), .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
      .fail_valid(fv1), .fail_op(fop1), .fail_idx(fidx1));

   alu_bist #(.NUM_RANDOM(0)) dut0 (
      .clk(clk), .rst_n(rst_n), .start(start), .srcA(a0), .srcB(b0), .ALUControl(c0),
      .ALUResult(r0), .zero(z0), .busy(busy0), .done(done0), .pass(pass0), .err_count(err0),
      .fail_valid(fv0), .fail_op(fop0), .fail_idx(fidx0));

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic build(input int nr);
      logic [31:0] s;
      vec_t v;
      s = SEED;
      vq.delete();
      for (int op = 0; op < 5; op++) begin
         for (int k = 0; k < nr + 25; k++) begin
            v.op  = 3'(op);
            v.idx = k;
            if (k < nr) begin
               s = (s >> 1) ^ (s[0] ? TAPS : 32'd0);
               v.a = s;
               s = (s >> 1) ^ (s[0] ? TAPS : 32'd0);
               v.b = s;
            end else begin
               v.a = cor[(k - nr) / 5];
               v.b = cor[(k - nr) % 5];
            end
            vq.push_back(v);
         end
      end
   endtask

   task automatic calc(output logic [7:0] e, output logic fv, output logic [2:0] fo,
                       output logic [7:0] fi);
      logic [32:0] got;
      logic [31:0] g;
      e = 8'd0; fv = 1'b0; fo = 3'd0; fi = 8'd0;
      foreach (vq[n]) begin
         g   = golden(vq[n].a, vq[n].b, vq[n].op);
         got = alu(vq[n].a, vq[n].b, vq[n].op, mode, fault_op, fault_key);
         if (got != {g == 32'd0, g}) begin
            if (e != 8'hFF) e++;
            if (!fv) begin fv = 1'b1; fo = vq[n].op; fi = 8'(vq[n].idx); end
         end
      end
   endtask

   task automatic run(input int pulse_at);
      logic [7:0] e0, i0, e1, i1;
      logic       v0, v1;
      logic [2:0] o0, o1;
      build(0);
      calc(e0, v0, o0, i0);
      build(NR);
      calc(e1, v1, o1, i1);
      @(negedge clk) start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      for (int n = 0; n < TOT; n++) begin
         @(negedge clk);
         chk("vec", {busy1, done1, a1, b1, c1}, {1'b1, 1'b0, vq[n].a, vq[n].b, vq[n].op});
         start = (n == pulse_at);
      end
      start = 1'b0;
      @(negedge clk);
      chk("end", {busy1, done1, pass1, err1, fv1, fop1, fidx1, a1, b1, c1},
          {1'b0, 1'b1, e1 == 8'd0, e1, v1, o1, i1, 32'd0, 32'd0, 3'd0});
      chk("end0", {busy0, done0, pass0, err0, fv0, fop0, fidx0},
          {1'b0, 1'b1, e0 == 8'd0, e0, v0, o0, i0});
      if (mode == 1) chk("slt_u", {err0, fop0, fidx0}, {8'd12, 3'd4, 8'd1});
      if (mode == 2) chk("zero0", {err0, fop0, fidx0}, {8'd38, 3'd0, 8'd0});
   endtask

   initial begin
      #2 rst_n = 1'b0;
      #1 chk("rst", {busy1, done1, pass1, err1, fv1, fop1, fidx1, a1, b1, c1}, 128'd0);
      repeat ($urandom_range(1, 4)) @(negedge clk);
      rst_n = 1'b1;
      mode = 0;
      run(40);
      run(-1);
      mode = 1;
      run(-1);
      mode = 2;
      run(-1);
      mode = 3;
      for (int t = 0; t < 3; t++) begin
         fault_op  = 3'($urandom_range(0, 4));
         fault_key = 2'($urandom_range(0, 3));
         run(-1);
      end
      mode = 2;
      @(negedge clk) start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (50) @(negedge clk);
      rst_n = 1'b0;
      #1 chk("rst_mid", {busy1, done1, pass1, err1, fv1, fop1, fidx1, a1, b1, c1}, 128'd0);
      chk("rst_mid0", {busy0, done0, pass0, err0, fv0, fop0, fidx0, a0, b0, c0}, 128'd0);
      @(negedge clk) rst_n = 1'b1;
      mode = 0;
      run(-1);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
